// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, mid-bit sampling frame FSM and a
// one-entry valid/ready output buffer with per-word error flags and sticky overrun.
module uart_rx #(
    parameter int CLOCK = 25000000,
    parameter int BAUD  = 115200,
    parameter int DBIT  = 8,
    parameter int SBIT  = 1,
    parameter int CHECK = 0
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            rx_i,
    output logic [DBIT-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            frame_err_o,
    output logic            parity_err_o,
    output logic            overrun_o
);
    localparam int DIV  = CLOCK / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DBIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            rxs_q;
    logic [CW-1:0]   baud_q;
    logic [BW-1:0]   bit_q;
    logic            stop_q;
    logic [DBIT-1:0] shift_q;
    logic            ferr_q;
    logic            perr_q;
    logic [DBIT-1:0] data_q;
    logic            valid_q;
    logic            ferr_out_q;
    logic            perr_out_q;
    logic            overrun_q;

    logic baud_done_d;
    logic last_stop_d;
    logic frame_err_d;
    logic parity_err_d;
    logic handshake_d;

    always_comb begin
        baud_done_d  = (baud_q == '0);
        last_stop_d  = (state_q == S_STOP) && baud_done_d && (stop_q == 1'(SBIT - 1));
        // Frame error accumulated over all stop samples, including the current one.
        frame_err_d  = ferr_q | ~rxs_q;
        parity_err_d = (CHECK == 1) ? ~(^{shift_q, rxs_q}) : (^{shift_q, rxs_q});
        handshake_d  = valid_q & ready_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_out_q <= 1'b0;
            perr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;

            if (handshake_d) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            // A completed frame either loads the buffer or is dropped as an overrun.
            if (last_stop_d) begin
                if (!valid_q || ready_i) begin
                    data_q     <= shift_q;
                    ferr_out_q <= frame_err_d;
                    perr_out_q <= perr_q;
                    valid_q    <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        baud_q  <= CW'(HALF - 1);
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done_d) begin
                        if (rxs_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            baud_q  <= CW'(DIV - 1);
                            bit_q   <= '0;
                            ferr_q  <= 1'b0;
                            perr_q  <= 1'b0;
                            state_q <= S_DATA;
                        end
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done_d) begin
                        shift_q <= {rxs_q, shift_q[DBIT-1:1]};
                        baud_q  <= CW'(DIV - 1);
                        if (bit_q == BW'(DBIT - 1)) begin
                            stop_q  <= 1'b0;
                            state_q <= (CHECK != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_done_d) begin
                        perr_q  <= parity_err_d;
                        baud_q  <= CW'(DIV - 1);
                        stop_q  <= 1'b0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done_d) begin
                        ferr_q <= frame_err_d;
                        baud_q <= CW'(DIV - 1);
                        if (stop_q == 1'(SBIT - 1)) begin
                            // A line still low after a bad stop bit is a break condition.
                            state_q <= (frame_err_d && !rxs_q) ? S_BREAK : S_IDLE;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_out_q;
    assign parity_err_o = perr_out_q;
    assign overrun_o    = overrun_q;

endmodule
